log_range_reduce: RTL and testbench
===================================

Name: log_range_reduce

Overview:
- Range-reduction stage directly upstream of the pipelined `log` unit.
- Takes a positive Q3.12 operand x and normalises it iteratively to x = m·2^k, with m in [1,2).
- Emits (m−1) in Q3.12, which is the operand format `log` consumes, plus the signed exponent k.
- A downstream recombiner forms ln(x) = ln(m) + k·ln2.
- Uses a valid/ready handshake on both sides, so a multi-cycle normalisation can stall the producer.

Parameters:
- WIDTH, 16, total operand width (1 sign, 3 integer, FRAC fraction bits).
- FRAC, 12, fraction bits; 1.0 = 2^FRAC.
- KW, 5, width of signed exponent output; must hold −FRAC..(WIDTH−FRAC−2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  operand x, Q3.12 two's complement.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept an operand.
- out_m1  out  WIDTH  m−1 in Q3.12, range 0x0000..0x0FFF.
- out_k  out  KW  signed exponent k.
- out_err  out  1  operand was ≤ 0 (ln undefined).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; work register, k, out_m1, out_k, out_err and out_valid are all 0.
  - in_ready=1 once RST=1.
- in_ready is 1 only in IDLE. out_valid is 1 only in DONE. Both are pure state decodes.
- IDLE: on in_valid & in_ready at a rising edge:
  - If in_data[WIDTH−1]=1 or in_data=0: out_err←1, out_m1←0, out_k←0, go to DONE. out_valid rises 1 cycle after the accept edge.
  - Otherwise: work←in_data, k←0, go to NORM.
- NORM evaluates one step per cycle:
  - If work ≥ 2.0 (any of bits [WIDTH−2:FRAC+1] set): work←work>>1 (logical shift, LSB truncated), k←k+1.
  - Else if work < 1.0 (bits [WIDTH−2:FRAC] all 0): work←work<<1, k←k−1.
  - Else: out_m1←{0, work[FRAC−1:0]}, out_k←k, out_err←0, go to DONE.
- Latency from accept edge to out_valid=1 is 2+|k| cycles: best 2, worst 14 (x=0x0001).
- Throughput is one operand per 3+|k| cycles with no backpressure. There is no overlap; in_ready stays 0 from accept until the DONE→IDLE transition.
- DONE: out_m1, out_k and out_err are held stable while out_ready=0. On out_ready=1: go to IDLE, out_valid falls the next cycle, in_ready=1.
- in_valid seen outside IDLE is ignored. The producer must hold its data until in_ready=1.
- k stays in [−12,+2] for WIDTH=16. No saturation logic is needed, and the NORM loop always terminates.
- Reset mid-NORM or mid-DONE aborts the operation immediately. The in-flight result is lost and no out_valid pulse is emitted.
- out_valid and in_ready are never both 1.

Decomposition:
- Shared package `log_pkg`:
  - Q3.12 constants: FRAC_BITS=12, ONE_Q=16'h1000, LN2_Q=16'h0B17 (for the recombiner).
  - State encoding: IDLE, NORM, DONE (2 bits).
  - Exponent width KW.
- No sub-module: a single FSM plus a shift register. The per-bit shift is too small to justify splitting out a normaliser.

Test Plan:
1. in_data=0x1000 (1.0) → out_m1=0x000, out_k=0, out_err=0; out_valid 2 cycles after the accept edge. Then in_data=0x2000 → m1=0x000, k=+1, latency 3.
2. in_data=0x3000 (3.0) → m1=0x800, k=+1. in_data=0x0C00 (0.75) → m1=0x800, k=−1. in_data=0x7FFF → m1=0xFFF, k=+2 (truncation), latency 4.
3. in_data=0x0001 → m1=0x000, k=−12, latency 14; in_ready=0 for that whole interval.
4. in_data=0x0000, then 0x8000, then 0xF000 → out_err=1, m1=0, k=0 each time; out_valid 1 cycle after accept.
5. Backpressure: result for 0x1800 held with out_ready=0 for 5 cycles → outputs stable (m1=0x800, k=0), in_ready=0, new in_valid ignored. After out_ready=1, the next operand is accepted one cycle later.
6. Assert RST=0 asynchronously mid-NORM for 0x0001 → all outputs 0 immediately. After release: in_ready=1, no stray out_valid, and the next operand 0x1000 gives m1=0, k=0.

Source files
------------

// File: rtl/log_pkg.sv
// Shared constants and types for the log datapath (range reduction, log core, recombiner).
package log_pkg;

  // Q3.12 fixed-point format
  localparam int unsigned FRAC_BITS = 12;
  localparam logic [15:0] ONE_Q     = 16'h1000;
  // ln(2) in Q3.12, used by the recombiner: ln(x) = ln(m) + k*ln2
  localparam logic [15:0] LN2_Q     = 16'h0B17;

  // Width of the signed exponent k
  localparam int unsigned KW_BITS = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StNorm = 2'd1,
    StDone = 2'd2
  } rr_state_e;

endpackage

// File: rtl/log_range_reduce.sv
// Range reduction ahead of the log unit: normalises a positive Q3.12 operand x to m*2^k with
// m in [1,2), one shift per cycle, and returns (m-1) in Q3.12 plus the signed exponent k.
module log_range_reduce
  import log_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = FRAC_BITS,
  parameter int unsigned KW    = KW_BITS
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_m1,
  output logic signed [KW-1:0] out_k,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  rr_state_e             state_q, state_d;
  logic [WIDTH-1:0]      work_q, work_d;
  logic signed [KW-1:0]  k_q, k_d;
  logic [WIDTH-1:0]      m1_q, m1_d;
  logic signed [KW-1:0]  ko_q, ko_d;
  logic                  err_q, err_d;

  logic ge_two;
  logic lt_one;
  logic bad_operand;

  // Magnitude classification of the working value and of the incoming operand
  always_comb begin
    ge_two      = |work_q[WIDTH-2:FRAC+1];
    lt_one      = ~|work_q[WIDTH-2:FRAC];
    bad_operand = in_data[WIDTH-1] | (in_data == '0);
  end

  // Next-state logic: accept in IDLE, one normalisation step per cycle in NORM, hold in DONE
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    k_d     = k_q;
    m1_d    = m1_q;
    ko_d    = ko_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (bad_operand) begin
            // ln undefined: report immediately without normalising
            err_d   = 1'b1;
            m1_d    = '0;
            ko_d    = '0;
            state_d = StDone;
          end else begin
            work_d  = in_data;
            k_d     = '0;
            state_d = StNorm;
          end
        end
      end
      StNorm: begin
        if (ge_two) begin
          work_d = work_q >> 1;
          k_d    = k_q + KW'(1);
        end else if (lt_one) begin
          work_d = work_q << 1;
          k_d    = k_q - KW'(1);
        end else begin
          m1_d    = {{(WIDTH-FRAC){1'b0}}, work_q[FRAC-1:0]};
          ko_d    = k_q;
          err_d   = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset aborts any in-flight operation
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      work_q  <= '0;
      k_q     <= '0;
      m1_q    <= '0;
      ko_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      k_q     <= k_d;
      m1_q    <= m1_d;
      ko_q    <= ko_d;
      err_q   <= err_d;
    end
  end

  // Handshake flags are pure state decodes so they can never both be high
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_m1    = m1_q;
    out_k     = ko_q;
    out_err   = err_q;
  end

endmodule

// File: tb/tb_log_range_reduce.sv
// Directed bench for log_range_reduce: vector table plus backpressure and reset sequences.
module tb_log_range_reduce;

  logic              CLK;
  logic              RST;
  logic [15:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       out_m1;
  logic signed [4:0] out_k;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;

  int checks;
  int failures;

  log_range_reduce #(
    .WIDTH(16),
    .FRAC (12),
    .KW   (5)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_m1   (out_m1),
    .out_k    (out_k),
    .out_err  (out_err),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic [15:0] m1;
    int          k;
    logic        err;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present an operand and let the accept edge pass; sample 1 time unit after it
  task automatic send(input logic [15:0] d);
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge (inclusive) until out_valid is seen
  task automatic wait_valid(input string name, input int exp_lat);
    int   lat;
    logic ready_low;
    lat       = 1;
    ready_low = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge CLK);
      #1;
      lat++;
    end
    chk({name, "_valid_seen"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_in_ready_low_busy"}, {31'd0, ready_low}, 32'd1);
    chk({name, "_in_ready_low_done"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_out(input string name, input logic [15:0] m1, input int k,
                           input logic err);
    int kact;
    kact = int'(out_k);
    chk({name, "_m1"}, {16'd0, out_m1}, {16'd0, m1});
    chk({name, "_k"}, kact, k);
    chk({name, "_err"}, {31'd0, out_err}, {31'd0, err});
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    chk({name, "_valid_falls"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  vec_t vecs[11];
  logic no_stray;

  initial begin
    checks    = 0;
    failures  = 0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    RST       = 1'b0;

    vecs[0]  = '{16'h1000, 16'h0000,   0, 1'b0,  2};
    vecs[1]  = '{16'h2000, 16'h0000,   1, 1'b0,  3};
    vecs[2]  = '{16'h3000, 16'h0800,   1, 1'b0,  3};
    vecs[3]  = '{16'h0C00, 16'h0800,  -1, 1'b0,  3};
    vecs[4]  = '{16'h7FFF, 16'h0FFF,   2, 1'b0,  4};
    vecs[5]  = '{16'h0001, 16'h0000, -12, 1'b0, 14};
    vecs[6]  = '{16'h0000, 16'h0000,   0, 1'b1,  1};
    vecs[7]  = '{16'h8000, 16'h0000,   0, 1'b1,  1};
    vecs[8]  = '{16'hF000, 16'h0000,   0, 1'b1,  1};
    vecs[9]  = '{16'h0FFF, 16'h0FFE,  -1, 1'b0,  3};
    vecs[10] = '{16'h5000, 16'h0400,   2, 1'b0,  4};

    // Reset state
    #12;
    check_out("reset", 16'h0000, 0, 1'b0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      string nm;
      nm = $sformatf("vec%0d_%h", i, vecs[i].data);
      send(vecs[i].data);
      wait_valid(nm, vecs[i].lat);
      check_out(nm, vecs[i].m1, vecs[i].k, vecs[i].err);
      release_result(nm);
    end

    // Backpressure: result held, competing in_valid ignored
    send(16'h1800);
    wait_valid("bp", 2);
    check_out("bp", 16'h0800, 0, 1'b0);
    in_data  = 16'h2000;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      #1;
      check_out($sformatf("bp_hold%0d", c), 16'h0800, 0, 1'b0);
      chk($sformatf("bp_hold%0d_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    wait_valid("bp_next", 3);
    check_out("bp_next", 16'h0000, 1, 1'b0);
    release_result("bp_next");

    // Asynchronous reset in the middle of a long normalisation
    send(16'h0001);
    repeat (4) @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check_out("rst_mid", 16'h0000, 0, 1'b0);
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    #3;
    RST = 1'b1;
    no_stray = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      #1;
      if (out_valid || !in_ready) no_stray = 1'b0;
    end
    chk("rst_no_stray_valid", {31'd0, no_stray}, 32'd1);
    send(16'h1000);
    wait_valid("post_rst", 2);
    check_out("post_rst", 16'h0000, 0, 1'b0);
    release_result("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
